// File: rtl/alu_pkg.sv
// Shared definitions for the ALU micro-program sequencer:
// op encodings, instruction layout and FSM states.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  localparam int INS_W    = 8;
  localparam int STOP_BIT = 7;
  localparam int OP_MSB   = 6;
  localparam int OP_LSB   = 4;
  localparam int IMM_MSB  = 3;
  localparam int IMM_LSB  = 0;

  // Packed view matching the field positions above.
  typedef struct packed {
    logic       stop;
    op_e        op;
    logic [3:0] imm;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_exec.sv
// Combinational ALU: y = a op b with zero/carry flags.
// Ports: a, b (W), op (op_e) in; y (W), zero, carry out.
module alu_exec
  import alu_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  op_e          op,
  output logic [W-1:0] y,
  output logic         zero,
  output logic         carry
);

  logic [W:0] wide;

  always_comb begin
    wide  = '0;
    y     = '0;
    carry = 1'b0;
    unique case (op)
      OP_ADD: begin
        wide  = {1'b0, a} + {1'b0, b};
        y     = wide[W-1:0];
        carry = wide[W];
      end
      OP_SUB: begin
        // bit W of the wide difference is the borrow
        wide  = {1'b0, a} - {1'b0, b};
        y     = wide[W-1:0];
        carry = wide[W];
      end
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
      OP_SHL: y = {a[W-2:0], 1'b0};
      OP_SHR: y = {1'b0, a[W-1:1]};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/alu_seq_ctrl.sv
// Micro-program sequencer: runs ACC <= ACC op IMM per cycle.
// Ports: program write, start/len/acc_init, hold; busy/done/err, acc/zero/carry.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [7:0]    prog_data,
  input  logic          start,
  input  logic [LW-1:0] start_len,
  input  logic [W-1:0]  acc_init,
  input  logic          hold,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [W-1:0]  acc,
  output logic          zero,
  output logic          carry
);

  state_e        state_q;
  logic [AW-1:0] pc_q;
  logic [LW-1:0] len_q;
  logic [W-1:0]  acc_q;
  logic          zero_q;
  logic          carry_q;
  logic          err_q;
  instr_t        mem_q [DEPTH];

  instr_t        cur;
  logic [W-1:0]  y_d;
  logic          zero_d;
  logic          carry_d;
  logic          len_ok;
  logic          last;

  assign cur = mem_q[pc_q];

  alu_exec #(.W(W)) u_alu (
    .a     (acc_q),
    .b     (cur.imm),
    .op    (cur.op),
    .y     (y_d),
    .zero  (zero_d),
    .carry (carry_d)
  );

  assign len_ok = (start_len != '0) &&
                  (start_len <= LW'(DEPTH));
  assign last   = ({1'b0, pc_q} == (len_q - LW'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      acc_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      err_q <= 1'b0;
      // writes land in IDLE/DONE only; a same-cycle
      // start still sees the new slot on its first read
      if (prog_we && (state_q != EXEC)) begin
        mem_q[prog_addr] <= instr_t'(prog_data);
      end
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (len_ok) begin
              state_q <= EXEC;
              acc_q   <= acc_init;
              pc_q    <= '0;
              len_q   <= start_len;
              zero_q  <= 1'b0;
              carry_q <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        EXEC: begin
          if (!hold) begin
            acc_q   <= y_d;
            zero_q  <= zero_d;
            carry_q <= carry_d;
            if (last || (cur.stop && zero_d)) begin
              state_q <= DONE;
            end else begin
              pc_q <= pc_q + AW'(1);
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy  = (state_q == EXEC);
  assign done  = (state_q == DONE);
  assign err   = err_q;
  assign acc   = acc_q;
  assign zero  = zero_q;
  assign carry = carry_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: vector table
// plus directed multi-cycle sequences.
module tb_alu_seq_ctrl;

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] AND = 3'd2;
  localparam logic [2:0] OR  = 3'd3;
  localparam logic [2:0] XOR = 3'd4;
  localparam logic [2:0] NOT = 3'd5;
  localparam logic [2:0] SHL = 3'd6;
  localparam logic [2:0] SHR = 3'd7;
  localparam int NV = 9;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       prog_we = 1'b0;
  logic [2:0] prog_addr = '0;
  logic [7:0] prog_data = '0;
  logic       start = 1'b0;
  logic [3:0] start_len = '0;
  logic [3:0] acc_init = '0;
  logic       hold = 1'b0;
  logic       busy, done, err, zero, carry;
  logic [3:0] acc;

  int pass_cnt = 0;
  int total_cnt = 0;

  typedef struct {
    logic [0:7][7:0] prog;
    int              n;
    logic [3:0]      init;
    logic [3:0]      acc;
    bit              z;
    bit              c;
    int              lat;
  } vec_t;

  vec_t vecs [NV];

  alu_seq_ctrl #(.DEPTH(8), .W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .start_len (start_len),
    .acc_init  (acc_init),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .acc       (acc),
    .zero      (zero),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] ins(bit s, logic [2:0] op,
                                     logic [3:0] imm);
    return {s, op, imm};
  endfunction

  function automatic vec_t mk(logic [0:7][7:0] p, int n,
                              logic [3:0] init, logic [3:0] a,
                              bit z, bit c, int lat);
    vec_t v;
    v.prog = p; v.n = n; v.init = init;
    v.acc = a; v.z = z; v.c = c; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 3'(a); prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  // hold is high for edges hf+1 .. hf+hc after the start edge
  task automatic run(input int n, input logic [3:0] init,
                     input int hf, input int hc, output int lat);
    lat = -1;
    @(negedge clk);
    acc_init = init; start_len = 4'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int k = 1; k <= 200; k++) begin
      hold = (k > hf) && (k <= hf + hc);
      @(negedge clk);
      if (done) begin
        lat = k;
        break;
      end
    end
    hold = 1'b0;
  endtask

  initial begin
    int lat;
    bit seen;
    logic [7:0] z8;
    z8 = 8'h00;

    vecs[0] = mk({ins(0,ADD,5), ins(0,SUB,2), ins(0,SHL,0),
                  z8, z8, z8, z8, z8}, 3, 4'h3, 4'hC, 0, 0, 3);
    vecs[1] = mk({ins(0,ADD,1), z8, z8, z8, z8, z8, z8, z8},
                 1, 4'hF, 4'h0, 1, 1, 1);
    vecs[2] = mk({ins(0,SUB,3), z8, z8, z8, z8, z8, z8, z8},
                 1, 4'h2, 4'hF, 0, 1, 1);
    vecs[3] = mk({ins(1,SUB,3), ins(0,ADD,7), ins(0,ADD,7),
                  ins(0,ADD,7), z8, z8, z8, z8},
                 4, 4'h3, 4'h0, 1, 0, 1);
    vecs[4] = mk({ins(0,AND,6), ins(0,OR,9), ins(0,XOR,15),
                  ins(0,NOT,3), z8, z8, z8, z8},
                 4, 4'hE, 4'hF, 0, 0, 4);
    vecs[5] = mk({ins(0,SHR,0), ins(0,SHR,0), z8, z8,
                  z8, z8, z8, z8}, 2, 4'h9, 4'h2, 0, 0, 2);
    vecs[6] = mk({ins(1,ADD,1), ins(1,SUB,1), ins(0,ADD,7),
                  ins(0,ADD,7), z8, z8, z8, z8},
                 4, 4'h0, 4'h0, 1, 0, 2);
    vecs[7] = mk({ins(0,SHL,0), z8, z8, z8, z8, z8, z8, z8},
                 1, 4'h8, 4'h0, 1, 0, 1);
    vecs[8] = mk({ins(0,ADD,1), ins(0,ADD,1), ins(0,ADD,1),
                  ins(0,ADD,1), ins(0,ADD,1), ins(0,ADD,1),
                  ins(0,ADD,1), ins(0,ADD,1)},
                 8, 4'h0, 4'h8, 0, 0, 8);

    #11;
    chk("rst_acc", acc, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_zero", zero, 0);
    chk("rst_carry", carry, 0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      for (int s = 0; s < 8; s++) wr(s, vecs[i].prog[s]);
      run(vecs[i].n, vecs[i].init, 0, 0, lat);
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_acc", i), acc, vecs[i].acc);
      chk($sformatf("v%0d_zero", i), zero, int'(vecs[i].z));
      chk($sformatf("v%0d_carry", i), carry, int'(vecs[i].c));
    end

    // chain step by step
    wr(0, ins(0,ADD,5)); wr(1, ins(0,SUB,2)); wr(2, ins(0,SHL,0));
    @(negedge clk);
    acc_init = 4'h3; start_len = 4'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk); chk("chain_e1", acc, 8);
    chk("chain_e1_done", done, 0);
    @(negedge clk); chk("chain_e2", acc, 6);
    @(negedge clk); chk("chain_e3", acc, 12);
    chk("chain_done", done, 1);
    chk("chain_busy_low", busy, 0);
    @(negedge clk); chk("chain_done_pulse", done, 0);
    @(negedge clk); chk("chain_hold_acc", acc, 12);

    // rejected starts leave acc at 12
    for (int r = 0; r < 2; r++) begin
      @(negedge clk);
      acc_init = 4'h7; start_len = (r == 0) ? 4'd0 : 4'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk($sformatf("rej%0d_err", r), err, 1);
      chk($sformatf("rej%0d_busy", r), busy, 0);
      @(negedge clk);
      chk($sformatf("rej%0d_err_pulse", r), err, 0);
      chk($sformatf("rej%0d_acc", r), acc, 12);
    end

    // write and start in the same IDLE cycle
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 3'd0; prog_data = ins(0,SUB,1);
    acc_init = 4'h3; start_len = 4'd1; start = 1'b1;
    @(negedge clk);
    prog_we = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("wr_start_done", done, 1);
    chk("wr_start_acc", acc, 2);

    // writes and starts during EXEC are ignored
    for (int s = 0; s < 4; s++) wr(s, ins(0,ADD,1));
    @(negedge clk);
    acc_init = 4'h0; start_len = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 3'd3; prog_data = ins(0,ADD,7);
    start = 1'b1; start_len = 4'd2;
    seen = 1'b0;
    lat = -1;
    for (int k = 2; k <= 50; k++) begin
      @(negedge clk);
      prog_we = 1'b0; start = 1'b0;
      if (err) seen = 1'b1;
      if (done) begin
        lat = k;
        break;
      end
    end
    chk("busywr_lat", lat, 4);
    chk("busywr_acc", acc, 4);
    chk("busy_start_no_err", seen, 0);
    run(4, 4'h0, 0, 0, lat);
    chk("busywr_rerun_acc", acc, 4);

    // hold adds latency but not a different result
    wr(0, ins(0,ADD,1)); wr(1, ins(0,ADD,2));
    wr(2, ins(0,ADD,3)); wr(3, ins(0,ADD,4));
    run(4, 4'h0, 0, 0, lat);
    chk("nohold_lat", lat, 4);
    chk("nohold_acc", acc, 10);
    run(4, 4'h0, 1, 2, lat);
    chk("hold_lat", lat, 6);
    chk("hold_acc", acc, 10);

    // reset mid-run
    @(negedge clk);
    acc_init = 4'h3; start_len = 4'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_acc", acc, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_zero", zero, 0);
    chk("arst_carry", carry, 0);
    chk("arst_err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    chk("arst_no_done", seen, 0);
    run(1, 4'h5, 0, 0, lat);
    chk("arst_slot_lat", lat, 1);
    chk("arst_slot_acc", acc, 5);
    chk("arst_slot_carry", carry, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
